wam_round_engine: RTL and testbench
===================================

Name: wam_round_engine

Overview:
Parametrised whack-a-mole game core for N moles. It runs a whole game: it picks a pseudo-random mole, lights it for a programmable on-time, judges keypad hits, and tracks score and misses. It implements all four game modes (normal, timed, deathmatch, level continuity). It sits between the difficulty/mode switch decode and the LED and keypad controllers, and replaces the single-channel light controller timing path.

Parameters:
N_MOLES, 9, number of moles/LEDs (2..16)
TW, 28, width of the on/between cycle-count inputs
CLK_HZ, 50_000_000, clock frequency; used for the 1 s tick in timed mode
TIMED_SECONDS, 30, length of a timed-mode game
MISS_LIMIT, 5, a player wins normal/timed/continuity only if misses < MISS_LIMIT
LEVEL_STEP, 5, hits per level-up in continuity mode
IW, clog2(N_MOLES), index width (derived)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a game
mode  in  4  one-hot: 0001 normal, 0010 timed, 0100 deathmatch, 1000 continuity
total_flicks  in  7  number of flicks per game (25 or 50 in practice)
light_on  in  TW  mole lit duration minus 1, in cycles
light_between  in  TW  gap duration minus 1, in cycles
hit_valid  in  1  one-cycle keypad press strobe
hit_idx  in  IW  pressed key index
lights  out  N_MOLES  one-hot lit mole
score  out  7  hits this game
misses  out  7  misses this game (timeouts + wrong key)
level  out  2  current level (continuity mode; 0 in all other modes)
busy  out  1  game in progress
game_over  out  1  held high from game end until next start
win  out  1  valid while game_over is high

Behaviour:
- Reset (async, active-low): state IDLE; lights=0; score=0; misses=0; level=0; busy=0; game_over=0; win=0; LFSR=nonzero seed 1.
- States are IDLE, GAP, LIT, DONE.
- IDLE/DONE → GAP on start: the engine samples mode, total_flicks, light_on and light_between, and clears score, misses, level and the flick count. It then sets busy=1 and game_over=0. Later changes to these inputs are ignored until the next start.
- start while busy is ignored.
- Non-one-hot mode decodes as normal.
- Timers count from 0 up to the target value, so a phase lasts target+1 cycles. A target of 0 gives 1 cycle.
- Continuity mode: effective target = input >> level.
- GAP: lights=0, and hits are ignored. On expiry the engine picks target mole t and enters LIT with lights=1<<t.
  - t is taken from the LFSR low bits; if t ≥ N, subtract N.
  - If t equals the previous mole, use (t+1) mod N.
- LIT:
  - hit_valid with hit_idx==t → score+1.
  - hit_valid with a wrong index, or timer expiry without a hit → misses+1.
  - Either outcome ends the flick: lights=0 and flick count +1 on the next cycle, then GAP.
  - A hit on the same cycle as expiry counts as a hit.
  - Latency: a hit in cycle k gives an updated score and lights=0 in cycle k+1.
- The LFSR (maximal length, ≥8 bits) advances every cycle, so the mole sequence depends on when the player presses start.
- Game end is evaluated when a flick ends:
  - normal/continuity: ends when flick count == total_flicks; win = misses < MISS_LIMIT.
  - deathmatch: ends on the first miss with win=0; reaching total_flicks gives win=1.
  - timed: total_flicks is ignored. A 1 s tick counter runs from start, and the game ends at TIMED_SECONDS even mid-flick, with lights cleared immediately. win = misses < MISS_LIMIT.
- Continuity: level increments after every LEVEL_STEP hits and saturates at 3.
- DONE: busy=0, game_over=1, and outputs hold their values.
- score and misses saturate at 127.
- total_flicks=0 in a count-terminated mode: the game ends immediately after start with win=1.
- Reset asserted mid-game returns the block to the reset values at once.

Decomposition:
- Package wam_pkg holds:
  - mode one-hot localparams
  - state encoding
  - LEVEL_MAX=3
  - default normal/extended flick counts (25, 50)
- One sub-module, wam_lfsr: parametrised width, enable input, nonzero seed, async active-low reset.

Test Plan:
1. N_MOLES=9, light_between=4, light_on=9, normal, total_flicks=3: hit the correct mole 2 cycles after each light → score=3, misses=0, game_over=1, win=1 after 3 flicks; each LIT window closes 1 cycle after the hit.
2. Deathmatch, total_flicks=25: no presses → first LIT times out after 10 cycles, misses=1, game_over=1, win=0, lights=0.
3. Continuity, LEVEL_STEP=2, light_on=15, total_flicks=8, always hit on expiry cycle → hits count (score=8), level steps 0,1,2,3, LIT length 16,8,4,2 cycles.
4. Timed, CLK_HZ=10, TIMED_SECONDS=3, no hits → game ends at cycle 30 after start mid-flick, lights=0, win = misses<5.
5. Wrong key: hit_idx ≠ lit mole in LIT → misses+1, score unchanged, next state GAP; consecutive moles never repeat over 200 flicks.
6. Reset asserted during LIT, plus start pulsed while busy → all outputs at reset values immediately; the mid-game start does not restart the flick count.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared constants and helpers for the whack-a-mole round engine.
package wam_pkg;

    // One-hot game mode codes as delivered by the mode switch decode.
    localparam logic [3:0] MODE_NORMAL     = 4'b0001;
    localparam logic [3:0] MODE_TIMED      = 4'b0010;
    localparam logic [3:0] MODE_DEATHMATCH = 4'b0100;
    localparam logic [3:0] MODE_CONTINUITY = 4'b1000;

    // Round engine state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_LIT  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Highest level reachable in continuity mode.
    localparam logic [1:0] LEVEL_MAX = 2'd3;

    // Flick counts offered by the front panel.
    localparam logic [6:0] FLICKS_NORMAL   = 7'd25;
    localparam logic [6:0] FLICKS_EXTENDED = 7'd50;

    // Anything that is not a recognised one-hot code plays as normal.
    function automatic logic [3:0] decode_mode(input logic [3:0] m);
        logic [3:0] r;
        case (m)
            MODE_TIMED, MODE_DEATHMATCH, MODE_CONTINUITY: r = m;
            default:                                      r = MODE_NORMAL;
        endcase
        return r;
    endfunction

    // Seven-bit increment that sticks at 127.
    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        logic [6:0] r;
        if (v == 7'd127) begin
            r = v;
        end else begin
            r = v + 7'd1;
        end
        return r;
    endfunction

    // Maximal-length Fibonacci tap masks for 8..16 bit registers.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] r;
        case (width)
            8:       r = 16'h00B8;
            9:       r = 16'h0110;
            10:      r = 16'h0240;
            11:      r = 16'h0500;
            12:      r = 16'h0829;
            13:      r = 16'h100D;
            14:      r = 16'h2015;
            15:      r = 16'h6000;
            default: r = 16'hD008;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running maximal-length LFSR used to choose the next mole.
// WIDTH must be 8..16 and SEED must be nonzero, otherwise the register locks up.
module wam_lfsr
    import wam_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic feedback_s;

    // Feedback bit is the parity of the tapped state bits.
    always_comb begin
        feedback_s = ^(state & TAPS);
    end

    // Shift left by one each enabled cycle; reset reloads the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[WIDTH-2:0], feedback_s};
        end else begin
            state <= state;
        end
    end

endmodule

// File: rtl/wam_round_engine.sv
// Whack-a-mole game core: picks moles, times the lit/gap phases, judges
// keypad hits and keeps score, misses and level for all four game modes.
module wam_round_engine
    import wam_pkg::*;
#(
    parameter int N_MOLES       = 9,
    parameter int TW            = 28,
    parameter int CLK_HZ        = 50_000_000,
    parameter int TIMED_SECONDS = 30,
    parameter int MISS_LIMIT    = 5,
    parameter int LEVEL_STEP    = 5,
    parameter int IW            = $clog2(N_MOLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         mode,
    input  logic [6:0]         total_flicks,
    input  logic [TW-1:0]      light_on,
    input  logic [TW-1:0]      light_between,
    input  logic               hit_valid,
    input  logic [IW-1:0]      hit_idx,
    output logic [N_MOLES-1:0] lights,
    output logic [6:0]         score,
    output logic [6:0]         misses,
    output logic [1:0]         level,
    output logic               busy,
    output logic               game_over,
    output logic               win
);

    localparam int LFSR_W = 16;
    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_W  = $clog2(TIMED_SECONDS + 1);
    localparam int STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TIMED_SECONDS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEVEL_STEP - 1);
    localparam logic [IW:0]       N_WIDE    = (IW+1)'(N_MOLES);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(N_MOLES - 1);
    localparam logic [6:0]        MISS_LIM  = 7'(MISS_LIMIT);

    logic [1:0]        state_r;
    logic [3:0]        mode_r;
    logic [6:0]        total_r;
    logic [TW-1:0]     on_r;
    logic [TW-1:0]     between_r;
    logic [TW-1:0]     timer_r;
    logic [6:0]        flick_r;
    logic [IW-1:0]     target_r;
    logic [STEP_W-1:0] step_r;
    logic [TICK_W-1:0] tick_r;
    logic [SEC_W-1:0]  sec_r;

    logic [LFSR_W-1:0] lfsr_s;
    logic              lfsr_unused_s;
    logic [TW-1:0]     eff_on_s;
    logic [TW-1:0]     eff_gap_s;
    logic [IW-1:0]     raw_s;
    logic [IW-1:0]     wrap_s;
    logic [IW-1:0]     pick_s;
    logic              hit_ok_s;
    logic              miss_evt_s;
    logic              flick_end_s;
    logic [6:0]        score_nxt_s;
    logic [6:0]        miss_nxt_s;
    logic [6:0]        flick_nxt_s;
    logic [1:0]        level_nxt_s;
    logic [STEP_W-1:0] step_nxt_s;
    logic              sec_end_s;
    logic              end_game_s;
    logic              end_win_s;

    // Runs every cycle so the mole sequence depends on when start arrives.
    wam_lfsr #(.WIDTH(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst_n (reset),
        .en    (1'b1),
        .state (lfsr_s)
    );

    // Only the low bits choose the mole; the rest just keep the sequence long.
    assign lfsr_unused_s = ^lfsr_s[LFSR_W-1:IW];

    // Phase targets shrink with level, and the next mole never repeats the last.
    always_comb begin
        eff_on_s  = on_r >> level;
        eff_gap_s = between_r >> level;
        raw_s     = lfsr_s[IW-1:0];
        if ({1'b0, raw_s} >= N_WIDE) begin
            wrap_s = raw_s - N_WIDE[IW-1:0];
        end else begin
            wrap_s = raw_s;
        end
        if (wrap_s != target_r) begin
            pick_s = wrap_s;
        end else if (wrap_s == IDX_LAST) begin
            pick_s = {IW{1'b0}};
        end else begin
            pick_s = wrap_s + IW'(1);
        end
    end

    // Judge the lit mole: a press wins over expiry in the same cycle.
    always_comb begin
        hit_ok_s    = 1'b0;
        miss_evt_s  = 1'b0;
        flick_end_s = 1'b0;
        if (state_r == ST_LIT) begin
            if (hit_valid) begin
                flick_end_s = 1'b1;
                hit_ok_s    = (hit_idx == target_r);
                miss_evt_s  = (hit_idx != target_r);
            end else if (timer_r == eff_on_s) begin
                flick_end_s = 1'b1;
                miss_evt_s  = 1'b1;
            end else begin
                flick_end_s = 1'b0;
            end
        end else begin
            flick_end_s = 1'b0;
        end
        score_nxt_s = hit_ok_s ? sat_inc7(score) : score;
        miss_nxt_s  = miss_evt_s ? sat_inc7(misses) : misses;
        flick_nxt_s = flick_r + 7'd1;
    end

    // Continuity levels climb once per LEVEL_STEP hits and stop at the top.
    always_comb begin
        level_nxt_s = level;
        step_nxt_s  = step_r;
        if ((mode_r == MODE_CONTINUITY) && hit_ok_s) begin
            if (step_r == STEP_LAST) begin
                step_nxt_s  = {STEP_W{1'b0}};
                level_nxt_s = (level == LEVEL_MAX) ? level : level + 2'd1;
            end else begin
                step_nxt_s  = step_r + STEP_W'(1);
                level_nxt_s = level;
            end
        end else begin
            level_nxt_s = level;
        end
    end

    // Decide whether the game finishes this cycle and how it is judged.
    always_comb begin
        end_game_s = 1'b0;
        end_win_s  = 1'b0;
        sec_end_s  = busy && (mode_r == MODE_TIMED) &&
                     (tick_r == TICK_LAST) && (sec_r == SEC_LAST);
        if (sec_end_s) begin
            end_game_s = 1'b1;
            end_win_s  = (miss_nxt_s < MISS_LIM);
        end else if ((state_r == ST_GAP) && (mode_r != MODE_TIMED) && (total_r == 7'd0)) begin
            end_game_s = 1'b1;
            end_win_s  = 1'b1;
        end else if (flick_end_s) begin
            case (mode_r)
                MODE_TIMED: begin
                    end_game_s = 1'b0;
                    end_win_s  = 1'b0;
                end
                MODE_DEATHMATCH: begin
                    if (miss_evt_s) begin
                        end_game_s = 1'b1;
                        end_win_s  = 1'b0;
                    end else begin
                        end_game_s = (flick_nxt_s == total_r);
                        end_win_s  = 1'b1;
                    end
                end
                default: begin
                    end_game_s = (flick_nxt_s == total_r);
                    end_win_s  = (miss_nxt_s < MISS_LIM);
                end
            endcase
        end else begin
            end_game_s = 1'b0;
        end
    end

    // One-second tick and seconds counter, restarted by each accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_r <= {TICK_W{1'b0}};
            sec_r  <= {SEC_W{1'b0}};
        end else if (!busy) begin
            tick_r <= {TICK_W{1'b0}};
            sec_r  <= {SEC_W{1'b0}};
        end else if (tick_r == TICK_LAST) begin
            tick_r <= {TICK_W{1'b0}};
            sec_r  <= sec_r + SEC_W'(1);
        end else begin
            tick_r <= tick_r + TICK_W'(1);
        end
    end

    // Main game sequencer: IDLE/DONE wait for start, GAP and LIT alternate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            mode_r    <= MODE_NORMAL;
            total_r   <= 7'd0;
            on_r      <= {TW{1'b0}};
            between_r <= {TW{1'b0}};
            timer_r   <= {TW{1'b0}};
            flick_r   <= 7'd0;
            target_r  <= {IW{1'b0}};
            step_r    <= {STEP_W{1'b0}};
            lights    <= {N_MOLES{1'b0}};
            score     <= 7'd0;
            misses    <= 7'd0;
            level     <= 2'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r   <= ST_GAP;
                        mode_r    <= decode_mode(mode);
                        total_r   <= total_flicks;
                        on_r      <= light_on;
                        between_r <= light_between;
                        timer_r   <= {TW{1'b0}};
                        flick_r   <= 7'd0;
                        step_r    <= {STEP_W{1'b0}};
                        lights    <= {N_MOLES{1'b0}};
                        score     <= 7'd0;
                        misses    <= 7'd0;
                        level     <= 2'd0;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_GAP: begin
                    if (end_game_s) begin
                        state_r   <= ST_DONE;
                        lights    <= {N_MOLES{1'b0}};
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        win       <= end_win_s;
                    end else if (timer_r == eff_gap_s) begin
                        state_r  <= ST_LIT;
                        target_r <= pick_s;
                        lights   <= {{(N_MOLES-1){1'b0}}, 1'b1} << pick_s;
                        timer_r  <= {TW{1'b0}};
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_LIT: begin
                    score  <= score_nxt_s;
                    misses <= miss_nxt_s;
                    level  <= level_nxt_s;
                    step_r <= step_nxt_s;
                    if (end_game_s) begin
                        state_r   <= ST_DONE;
                        flick_r   <= flick_nxt_s;
                        lights    <= {N_MOLES{1'b0}};
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        win       <= end_win_s;
                    end else if (flick_end_s) begin
                        state_r <= ST_GAP;
                        flick_r <= flick_nxt_s;
                        lights  <= {N_MOLES{1'b0}};
                        timer_r <= {TW{1'b0}};
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wam_round_engine.sv
// Directed self-checking bench for wam_round_engine (N=9, fast timed mode,
// two hits per level).
module tb_wam_round_engine;
    import wam_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mode;
    logic [6:0]  total_flicks;
    logic [27:0] light_on;
    logic [27:0] light_between;
    logic        hit_valid;
    logic [3:0]  hit_idx;
    logic [8:0]  lights;
    logic [6:0]  score;
    logic [6:0]  misses;
    logic [1:0]  level;
    logic        busy;
    logic        game_over;
    logic        win;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wam_round_engine #(
        .N_MOLES(9), .TW(28), .CLK_HZ(10), .TIMED_SECONDS(3),
        .MISS_LIMIT(5), .LEVEL_STEP(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .total_flicks(total_flicks), .light_on(light_on),
        .light_between(light_between), .hit_valid(hit_valid),
        .hit_idx(hit_idx), .lights(lights), .score(score),
        .misses(misses), .level(level), .busy(busy),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [3:0] m, input logic [6:0] n,
                              input logic [27:0] on_c, input logic [27:0] gap_c);
        mode = m;
        total_flicks = n;
        light_on = on_c;
        light_between = gap_c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Cycles spent waiting for a mole to light; -1 if none appears.
    task automatic wait_lit(output int waited);
        waited = 0;
        while (lights == 9'd0 && waited < 64) begin
            step();
            waited++;
        end
        if (lights == 9'd0) waited = -1;
    endtask

    function automatic int lit_index(input logic [8:0] l);
        int r = -1;
        for (int i = 0; i < 9; i++) if (l[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mode = MODE_NORMAL; total_flicks = 7'd0;
        light_on = 28'd0; light_between = 28'd0; hit_valid = 1'b0; hit_idx = 4'd0;
        repeat (3) step();
        total_cnt++;
        if ({lights, score, misses, level, busy, game_over, win} !== 28'd0)
            $display("FAIL reset_outputs: got %h required 0", {lights, score, misses, level, busy, game_over, win});
        else pass_cnt++;
        reset = 1'b1;
        step();
        total_cnt++;
        if (busy !== 1'b0 || game_over !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b game_over=%b required 0 0", busy, game_over);
        else pass_cnt++;
    endtask

    task automatic test_normal_hits();
        int w, idx;
        start_game(MODE_NORMAL, 7'd3, 28'd9, 28'd4);
        total_cnt++;
        if (busy !== 1'b1 || game_over !== 1'b0)
            $display("FAIL start_busy: busy=%b game_over=%b required 1 0", busy, game_over);
        else pass_cnt++;
        for (int f = 0; f < 3; f++) begin
            wait_lit(w);
            idx = lit_index(lights);
            total_cnt++;
            if (w != 5) $display("FAIL normal_gap_len: got %0d required 5", w);
            else pass_cnt++;
            total_cnt++;
            if ($countones(lights) != 1 || idx < 0)
                $display("FAIL normal_onehot: lights=%b required one-hot", lights);
            else pass_cnt++;
            step();
            step();
            total_cnt++;
            if (lights === 9'd0) $display("FAIL normal_still_lit: lights=%b required nonzero", lights);
            else pass_cnt++;
            hit_valid = 1'b1;
            hit_idx = 4'(idx);
            step();
            hit_valid = 1'b0;
            total_cnt++;
            if (lights !== 9'd0 || score !== 7'(f + 1))
                $display("FAIL normal_hit_latency: lights=%b score=%0d required 0 %0d", lights, score, f + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (score !== 7'd3 || misses !== 7'd0 || game_over !== 1'b1 || win !== 1'b1 || busy !== 1'b0)
            $display("FAIL normal_end: score=%0d misses=%0d go=%b win=%b busy=%b required 3 0 1 1 0",
                     score, misses, game_over, win, busy);
        else pass_cnt++;
    endtask

    task automatic test_deathmatch();
        int w, n;
        start_game(MODE_DEATHMATCH, FLICKS_NORMAL, 28'd9, 28'd4);
        wait_lit(w);
        n = 0;
        while (lights != 9'd0 && n < 50) begin
            n++;
            step();
        end
        total_cnt++;
        if (n != 10) $display("FAIL death_lit_len: got %0d required 10", n);
        else pass_cnt++;
        total_cnt++;
        if (misses !== 7'd1 || score !== 7'd0 || game_over !== 1'b1 || win !== 1'b0 || busy !== 1'b0)
            $display("FAIL death_end: misses=%0d score=%0d go=%b win=%b busy=%b required 1 0 1 0 0",
                     misses, score, game_over, win, busy);
        else pass_cnt++;
    endtask

    task automatic test_continuity();
        int w, idx, lvl, exp_len, exp_gap;
        start_game(MODE_CONTINUITY, 7'd8, 28'd15, 28'd4);
        for (int f = 0; f < 8; f++) begin
            lvl = (f / 2 > 3) ? 3 : f / 2;
            exp_len = 16 >> lvl;
            exp_gap = (4 >> lvl) + 1;
            wait_lit(w);
            idx = lit_index(lights);
            total_cnt++;
            if (w != exp_gap) $display("FAIL cont_gap_len: flick %0d got %0d required %0d", f, w, exp_gap);
            else pass_cnt++;
            total_cnt++;
            if (level !== 2'(lvl)) $display("FAIL cont_level: flick %0d got %0d required %0d", f, level, lvl);
            else pass_cnt++;
            repeat (exp_len - 1) step();
            total_cnt++;
            if (lights === 9'd0) $display("FAIL cont_lit_len: flick %0d lit ended before cycle %0d", f, exp_len);
            else pass_cnt++;
            hit_valid = 1'b1;
            hit_idx = 4'(idx);
            step();
            hit_valid = 1'b0;
            total_cnt++;
            if (lights !== 9'd0 || score !== 7'(f + 1))
                $display("FAIL cont_expiry_hit: flick %0d lights=%b score=%0d required 0 %0d", f, lights, score, f + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (score !== 7'd8 || level !== 2'd3 || misses !== 7'd0 || game_over !== 1'b1 || win !== 1'b1)
            $display("FAIL cont_end: score=%0d level=%0d misses=%0d go=%b win=%b required 8 3 0 1 1",
                     score, level, misses, game_over, win);
        else pass_cnt++;
    endtask

    task automatic test_timed();
        start_game(MODE_TIMED, 7'd0, 28'd12, 28'd4);
        repeat (29) step();
        total_cnt++;
        if (busy !== 1'b1 || lights === 9'd0 || misses !== 7'd1)
            $display("FAIL timed_before_end: busy=%b lights=%b misses=%0d required 1 lit 1", busy, lights, misses);
        else pass_cnt++;
        step();
        total_cnt++;
        if (game_over !== 1'b1 || busy !== 1'b0 || lights !== 9'd0 || win !== 1'b1 || misses !== 7'd1 || score !== 7'd0)
            $display("FAIL timed_end: go=%b busy=%b lights=%b win=%b misses=%0d score=%0d required 1 0 0 1 1 0",
                     game_over, busy, lights, win, misses, score);
        else pass_cnt++;
    endtask

    task automatic test_zero_flicks();
        start_game(MODE_NORMAL, 7'd0, 28'd9, 28'd4);
        step();
        total_cnt++;
        if (game_over !== 1'b1 || win !== 1'b1 || busy !== 1'b0 || score !== 7'd0)
            $display("FAIL zero_flicks: go=%b win=%b busy=%b score=%0d required 1 1 0 0", game_over, win, busy, score);
        else pass_cnt++;
    endtask

    task automatic test_wrong_key();
        int w, idx, idx2;
        start_game(MODE_NORMAL, 7'd2, 28'd9, 28'd4);
        wait_lit(w);
        idx = lit_index(lights);
        step();
        hit_valid = 1'b1;
        hit_idx = 4'((idx + 1) % 9);
        step();
        hit_valid = 1'b0;
        total_cnt++;
        if (lights !== 9'd0 || misses !== 7'd1 || score !== 7'd0 || busy !== 1'b1)
            $display("FAIL wrong_key: lights=%b misses=%0d score=%0d busy=%b required 0 1 0 1", lights, misses, score, busy);
        else pass_cnt++;
        hit_valid = 1'b1;
        hit_idx = 4'd0;
        step();
        hit_valid = 1'b0;
        total_cnt++;
        if (misses !== 7'd1 || score !== 7'd0)
            $display("FAIL gap_hit_ignored: misses=%0d score=%0d required 1 0", misses, score);
        else pass_cnt++;
        wait_lit(w);
        idx2 = lit_index(lights);
        total_cnt++;
        if (w != 4) $display("FAIL wrong_key_gap: got %0d required 4", w);
        else pass_cnt++;
        total_cnt++;
        if (idx2 == idx) $display("FAIL wrong_key_repeat: got %0d required not %0d", idx2, idx);
        else pass_cnt++;
        hit_valid = 1'b1;
        hit_idx = 4'(idx2);
        step();
        hit_valid = 1'b0;
        total_cnt++;
        if (score !== 7'd1 || game_over !== 1'b1 || win !== 1'b1)
            $display("FAIL wrong_key_end: score=%0d go=%b win=%b required 1 1 1", score, game_over, win);
        else pass_cnt++;
    endtask

    task automatic test_no_repeat();
        int repeats = 0;
        int bad = 0;
        int prev, idx, w;
        for (int g = 0; g < 4; g++) begin
            start_game(MODE_NORMAL, FLICKS_EXTENDED, 28'd0, 28'd0);
            prev = -1;
            for (int f = 0; f < 50; f++) begin
                wait_lit(w);
                idx = lit_index(lights);
                if (w != 1 || idx < 0) bad++;
                if (idx == prev) repeats++;
                prev = idx;
                step();
            end
            total_cnt++;
            if (misses !== 7'd50 || game_over !== 1'b1 || win !== 1'b0)
                $display("FAIL repeat_game_end: game %0d misses=%0d go=%b win=%b required 50 1 0", g, misses, game_over, win);
            else pass_cnt++;
        end
        total_cnt++;
        if (repeats != 0) $display("FAIL no_repeat: got %0d repeats required 0", repeats);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL fast_flick_timing: got %0d bad flicks required 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_busy_start_and_reset();
        int w, idx;
        start_game(MODE_NORMAL, 7'd2, 28'd9, 28'd4);
        wait_lit(w);
        idx = lit_index(lights);
        mode = MODE_DEATHMATCH;
        total_flicks = 7'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || lit_index(lights) != idx)
            $display("FAIL busy_start_ignored: busy=%b lights=%b required 1 mole %0d", busy, lights, idx);
        else pass_cnt++;
        hit_valid = 1'b1;
        hit_idx = 4'(idx);
        step();
        hit_valid = 1'b0;
        wait_lit(w);
        idx = lit_index(lights);
        hit_valid = 1'b1;
        hit_idx = 4'(idx);
        step();
        hit_valid = 1'b0;
        total_cnt++;
        if (score !== 7'd2 || game_over !== 1'b1 || win !== 1'b1)
            $display("FAIL busy_start_count: score=%0d go=%b win=%b required 2 1 1", score, game_over, win);
        else pass_cnt++;
        start_game(MODE_NORMAL, 7'd5, 28'd9, 28'd4);
        wait_lit(w);
        hit_valid = 1'b1;
        hit_idx = 4'(lit_index(lights));
        step();
        hit_valid = 1'b0;
        wait_lit(w);
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({lights, score, misses, level, busy, game_over, win} !== 28'd0)
            $display("FAIL midgame_reset: got %h required 0", {lights, score, misses, level, busy, game_over, win});
        else pass_cnt++;
        step();
        reset = 1'b1;
        step();
        total_cnt++;
        if (busy !== 1'b0 || lights !== 9'd0 || score !== 7'd0)
            $display("FAIL post_reset_idle: busy=%b lights=%b score=%0d required 0 0 0", busy, lights, score);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_normal_hits();
        test_deathmatch();
        test_continuity();
        test_timed();
        test_zero_flicks();
        test_wrong_key();
        test_no_repeat();
        test_busy_start_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
